// File: rtl/pre_scr_deser.sv
// Transmit-side bit-to-word deserializer feeding the scrambler input FIFO.
// Define PRE_SCR_DESER_MSB_FIRST_EN for MSB-first, right-justified packing.
module pre_scr_deser (
    input  logic        clk,
    input  logic        clk_en,
    input  logic        rst,
    input  logic        bit_in,
    input  logic        bit_wr,
    input  logic        flush,
    output logic        bit_rdy,
    input  logic        scrambled_full,
    output logic        scrambled_wr,
    output logic [63:0] data_out,
    output logic [6:0]  size_out
);

    typedef enum logic {
        FILL = 1'b0,
        PUSH = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [6:0]  count;
    logic [6:0]  count_nxt;
    logic [6:0]  fill_cnt;
    logic [63:0] acc;
    logic [63:0] acc_nxt;
    logic [63:0] fill_acc;
    logic [63:0] data_nxt;
    logic [6:0]  size_nxt;
    logic        wr_nxt;
    logic        take;

    assign bit_rdy = (state == FILL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FILL;
            count        <= 7'd0;
            acc          <= 64'd0;
            data_out     <= 64'd0;
            size_out     <= 7'd0;
            scrambled_wr <= 1'b0;
        end else if (clk_en) begin
            state        <= state_nxt;
            count        <= count_nxt;
            acc          <= acc_nxt;
            data_out     <= data_nxt;
            size_out     <= size_nxt;
            scrambled_wr <= wr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        acc_nxt   = acc;
        data_nxt  = data_out;
        size_nxt  = size_out;
        wr_nxt    = 1'b0;
        take      = bit_wr & (state == FILL);
        fill_cnt  = count + {6'd0, take};
        fill_acc  = acc;

        if (take) begin
`ifdef PRE_SCR_DESER_MSB_FIRST_EN
            fill_acc = {acc[62:0], bit_in};
`else
            fill_acc[count[5:0]] = bit_in;
`endif
        end

        unique case (state)
            FILL: begin
                count_nxt = fill_cnt;
                acc_nxt   = fill_acc;
                // A full word or a flush with buffered bits closes the word
                if (fill_cnt[6] || (flush && (fill_cnt != 7'd0))) begin
                    data_nxt  = fill_acc;
                    size_nxt  = fill_cnt;
                    count_nxt = 7'd0;
                    acc_nxt   = 64'd0;
                    state_nxt = PUSH;
                end
            end
            PUSH: begin
                if (!scrambled_full) begin
                    wr_nxt    = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

endmodule
